// File: rtl/div16_pkg.sv
// div16_pkg: shared types and constants for the iterative restoring divider
package div16_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int WIDTH_DEF = 16;
    localparam logic signed [WIDTH_DEF-1:0] DBZ_QUOTIENT = '1;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
    localparam int CNT_W = cnt_w(WIDTH_DEF);
endpackage

// File: rtl/div16_step.sv
// div16_step: one combinational restoring-division step (shift in a dividend bit, trial subtract)
module div16_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    // The shifted value keeps the old remainder MSB so divisors above 2^(WIDTH-1) still divide correctly.
    logic [WIDTH:0] shifted, trial;
    assign shifted  = {rem, bit_in};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
endmodule

// File: rtl/div16_restoring.sv
// div16_restoring: iterative restoring divider, one quotient bit per clock; DIV16_SIGNED_EN selects two's-complement operands
module div16_restoring
    import div16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(DBZ_QUOTIENT);

    state_t state;
    logic [WIDTH-1:0] rem, q, dvs, rem_next, q_next, a_mag, b_mag;
    logic [CW-1:0] count;
    logic q_bit, neg_q, neg_r, sign_q, sign_r, zero_div;

`ifdef DIV16_SIGNED_EN
    assign a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag  = divisor[WIDTH-1] ? -divisor : divisor;
    assign sign_q = dividend[WIDTH-1] ^ divisor[WIDTH-1];
    assign sign_r = dividend[WIDTH-1];
`else
    assign a_mag  = dividend;
    assign b_mag  = divisor;
    assign sign_q = 1'b0;
    assign sign_r = 1'b0;
`endif

    assign zero_div  = divisor == '0;
    assign q_next    = {q[WIDTH-2:0], q_bit};
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    div16_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .bit_in   (q[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Control FSM plus datapath: accept in IDLE, iterate in RUN, hold results in DONE until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            q           <= '0;
            dvs         <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    div_by_zero <= zero_div;
                    rem         <= '0;
                    q           <= zero_div ? dividend : a_mag;
                    dvs         <= b_mag;
                    count       <= CW'(WIDTH - 1);
                    neg_q       <= sign_q;
                    neg_r       <= sign_r;
                    state       <= RUN;
                end
                RUN: begin
                    rem   <= rem_next;
                    q     <= q_next;
                    count <= count - 1'b1;
                    if (div_by_zero) begin
                        quotient  <= DBZ_Q;
                        remainder <= q;
                        state     <= DONE;
                    end else if (count == '0) begin
                        quotient  <= neg_q ? -q_next : q_next;
                        remainder <= neg_r ? -rem_next : rem_next;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div16_restoring.sv
// tb_div16_restoring: directed and random operations against an arithmetic reference model
module tb_div16_restoring;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
    logic [15:0] dividend, divisor, quotient, remainder;
    int total = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div16_restoring #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {dbz, quotient, remainder} from plain language arithmetic.
    function automatic logic [32:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] rq, rr;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 16'd0) begin
            rq = 16'hFFFF;
            rr = a;
        end else begin
`ifdef DIV16_SIGNED_EN
            rq = 16'(sa / sb);
            rr = 16'(sa % sb);
`else
            rq = a / b;
            rr = a % b;
            if (sa == sb) rq = rq;
`endif
        end
        return {b == 16'd0, rq, rr};
    endfunction

    task automatic op(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [32:0] e;
        int lat;
        e = ref_div(a, b);
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency %0d/%0d", a, b), lat, (b == 16'd0) ? 1 : 16);
        chk($sformatf("quotient %0d/%0d", a, b), quotient, e[31:16]);
        chk($sformatf("remainder %0d/%0d", a, b), remainder, e[15:0]);
        chk($sformatf("div_by_zero %0d/%0d", a, b), div_by_zero, e[32]);
        chk("in_ready_in_done", in_ready, 0);
        chk("busy_in_done", busy, 1);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk("held_quotient", quotient, e[31:16]);
            chk("held_remainder", remainder, e[15:0]);
            chk("held_out_valid", out_valid, 1);
            chk("held_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_consume", in_ready, 1);
        chk("out_valid_after_consume", out_valid, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_div_by_zero", div_by_zero, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);

        op(16'd100, 16'd7, 0);
        op(16'd65535, 16'd1, 0);
        op(16'd3, 16'd10, 0);
        op(16'd5, 16'd0, 0);
        op(16'd1000, 16'd33, 10);
        op(16'hFFF9, 16'd2, 0);
        op(16'h8000, 16'hFFFF, 0);
        op(16'hFFFF, 16'hFFFE, 0);
        op(16'h1234, 16'h8001, 1);

        dividend = 16'd1000;
        divisor  = 16'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_mid_run", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_reset_quotient", quotient, 0);
        chk("midrun_reset_remainder", remainder, 0);
        chk("midrun_reset_div_by_zero", div_by_zero, 0);
        chk("midrun_reset_out_valid", out_valid, 0);
        chk("midrun_reset_in_ready", in_ready, 1);
        chk("midrun_reset_busy", busy, 0);
        op(16'd9, 16'd3, 0);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom_range(1, 15));
                1: rb = 16'd0;
                default: rb = 16'($urandom);
            endcase
            op(ra, rb, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
